dungv_core_seq: RTL

- Parametrised multicycle sequencer and register file for the DungV core. Replaces the free-running fetch/execute in the board-level top.
- Owns the PC, register file, output latch and an explicit FSM.
- Talks to instruction memory, ALU and data memory through valid/ready handshakes, so each can have variable latency.
- The board top instantiates it between the oscillator, memories and pins.

---
 rtl/dungv_pkg.sv | 55 +++++
 rtl/dungv_regfile.sv | 42 ++++
 rtl/dungv_core_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dungv_pkg.sv
// dungv_pkg: instruction class/opcode encodings and sequencer state type for the DungV core.
// Optional build macro DUNGV_ZERO_REG_EN (R0 hardwired to zero) is consumed by dungv_regfile.
package dungv_pkg;

    localparam logic [1:0] CLS_SYS = 2'd0;
    localparam logic [1:0] CLS_ALU = 2'd1;
    localparam logic [1:0] CLS_MOV = 2'd2;
    localparam logic [1:0] CLS_MEM = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SUBI = 4'h7;
    localparam logic [3:0] OP_SHLI = 4'h8;
    localparam logic [3:0] OP_SHRI = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_XORI = 4'hB;
    localparam logic [3:0] OP_JEQ  = 4'hC;
    localparam logic [3:0] OP_JNE  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;

    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_STI  = 4'h3;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_IWAIT,
        ST_EXEC,
        ST_AWAIT,
        ST_MWAIT,
        ST_WB,
        ST_HALT
    } state_e;

    function automatic logic op_legal(input logic [1:0] cls, input logic [3:0] oper);
        logic ok;
        case (cls)
            CLS_SYS: ok = (oper == OP_NOP) || (oper == OP_HALT);
            CLS_ALU: ok = (oper != OP_NOP) && (oper != OP_HALT);
            CLS_MOV: ok = (oper == OP_MOV) || (oper == OP_LDI);
            default: ok = (oper == OP_LD) || (oper == OP_ST) || (oper == OP_STI);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dungv_regfile.sv
// dungv_regfile: 2 async read ports, 1 sync write port, async active-low clear.
// With DUNGV_ZERO_REG_EN defined, R0 reads as zero and writes to it are dropped.
module dungv_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [REG_AW-1:0] rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);
    localparam int unsigned NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_en;

`ifdef DUNGV_ZERO_REG_EN
    assign wr_en     = we_i && (wa_i != '0);
    assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
`else
    assign wr_en     = we_i;
    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

endmodule

// File: rtl/dungv_core_seq.sv
// dungv_core_seq: multicycle fetch/execute sequencer with PC, register file and output latch.
// Build option DUNGV_ZERO_REG_EN (R0 hardwired to zero) is passed through to dungv_regfile.
module dungv_core_seq #(
    parameter int  DATA_W  = 16,
    parameter int  REG_AW  = 6,
    parameter int  PC_W    = 8,
    parameter int  MADDR_W = 10,
    parameter int  IMM_W   = 16,
    localparam int INSTR_W = 6 + 2 * REG_AW + IMM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               alu_start,
    output logic [3:0]         alu_oper,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic               alu_done,
    input  logic [DATA_W-1:0]  alu_q,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [MADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  out_data,
    output logic               halted,
    output logic               illegal
);
    import dungv_pkg::*;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               imem_req_q, imem_req_d;
    logic               alu_start_q, alu_start_d;
    logic [3:0]         alu_oper_q, alu_oper_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [MADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]  dmem_wdata_q, dmem_wdata_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic               wb_en_q, wb_en_d;
    logic [REG_AW-1:0]  wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0]  wb_val_q, wb_val_d;

    logic [1:0]         cls_f;
    logic [3:0]         oper_f;
    logic [REG_AW-1:0]  ra_f, rb_f;
    logic [IMM_W-1:0]   imm_f;
    logic [DATA_W-1:0]  rd_a, rd_b;
    logic [PC_W-1:0]    pc_inc, tgt_pc;
    logic               rf_we;

    assign cls_f  = ir_q[INSTR_W-1 -: 2];
    assign oper_f = ir_q[INSTR_W-3 -: 4];
    assign ra_f   = ir_q[IMM_W+2*REG_AW-1 -: REG_AW];
    assign rb_f   = ir_q[IMM_W+REG_AW-1 -: REG_AW];
    assign imm_f  = ir_q[IMM_W-1:0];

    assign pc_inc = pc_q + PC_W'(1);
    assign tgt_pc = PC_W'(imm_f);

    // Register writes are deferred to WB so a single write port serves MOV/LDI, ALU and load.
    assign rf_we = (state_q == ST_WB) && wb_en_q;

    dungv_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ra_addr_i (ra_f),
        .ra_data_o (rd_a),
        .rb_addr_i (rb_f),
        .rb_data_o (rd_b),
        .we_i      (rf_we),
        .wa_i      (wb_dst_q),
        .wd_i      (wb_val_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            imem_req_q   <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_oper_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            out_q        <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_dst_q     <= '0;
            wb_val_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            imem_req_q   <= imem_req_d;
            alu_start_q  <= alu_start_d;
            alu_oper_q   <= alu_oper_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            out_q        <= out_d;
            halted_q     <= halted_d;
            illegal_q    <= illegal_d;
            wb_en_q      <= wb_en_d;
            wb_dst_q     <= wb_dst_d;
            wb_val_q     <= wb_val_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        imem_req_d   = imem_req_q;
        alu_start_d  = 1'b0;
        alu_oper_d   = alu_oper_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        out_d        = out_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        wb_en_d      = wb_en_q;
        wb_dst_d     = wb_dst_q;
        wb_val_d     = wb_val_q;

        case (state_q)
            ST_FETCH: begin
                imem_req_d = 1'b1;
                state_d    = ST_IWAIT;
            end
            ST_IWAIT: begin
                if (imem_valid) begin
                    ir_d       = imem_data;
                    imem_req_d = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (!op_legal(cls_f, oper_f)) begin
                    illegal_d = 1'b1;
                end else begin
                    case (cls_f)
                        CLS_SYS: begin
                            if (oper_f == OP_HALT) begin
                                pc_d     = pc_q;
                                halted_d = 1'b1;
                                state_d  = ST_HALT;
                            end
                        end
                        CLS_ALU: begin
                            if (oper_f == OP_JEQ) begin
                                pc_d = (rd_a == rd_b) ? tgt_pc : pc_inc;
                            end else if (oper_f == OP_JNE) begin
                                pc_d = (rd_a != rd_b) ? tgt_pc : pc_inc;
                            end else if (oper_f == OP_JMP) begin
                                pc_d = tgt_pc;
                            end else begin
                                pc_d        = pc_q;
                                alu_start_d = 1'b1;
                                alu_oper_d  = oper_f;
                                alu_a_d     = rd_a;
                                if (oper_f <= OP_XOR) begin
                                    alu_b_d = rd_b;
                                end else if (oper_f == OP_NOT) begin
                                    alu_b_d = '0;
                                end else begin
                                    alu_b_d = DATA_W'(rb_f);
                                end
                                wb_dst_d = (oper_f == OP_NOT) ? rb_f : ra_f;
                                state_d  = ST_AWAIT;
                            end
                        end
                        CLS_MOV: begin
                            pc_d     = pc_q;
                            wb_en_d  = 1'b1;
                            wb_dst_d = ra_f;
                            wb_val_d = (oper_f == OP_MOV) ? rd_b : DATA_W'(imm_f);
                            state_d  = ST_WB;
                        end
                        default: begin
                            pc_d         = pc_q;
                            dmem_req_d   = 1'b1;
                            dmem_addr_d  = MADDR_W'(imm_f);
                            dmem_we_d    = (oper_f != OP_LD);
                            dmem_wdata_d = (oper_f == OP_ST)  ? rd_a :
                                           (oper_f == OP_STI) ? DATA_W'(imm_f) : '0;
                            wb_dst_d     = ra_f;
                            state_d      = ST_MWAIT;
                        end
                    endcase
                end
            end
            ST_AWAIT: begin
                if (alu_done) begin
                    wb_en_d    = 1'b1;
                    wb_val_d   = alu_q;
                    alu_oper_d = '0;
                    alu_a_d    = '0;
                    alu_b_d    = '0;
                    state_d    = ST_WB;
                end
            end
            ST_MWAIT: begin
                if (dmem_ack) begin
                    if (dmem_we_q) begin
                        out_d = dmem_wdata_q;
                    end else begin
                        wb_en_d  = 1'b1;
                        wb_val_d = dmem_rdata;
                    end
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_addr_d  = '0;
                    dmem_wdata_d = '0;
                    state_d      = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_en_q) begin
                    out_d = wb_val_q;
                end
                wb_en_d = 1'b0;
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign alu_start  = alu_start_q;
    assign alu_oper   = alu_oper_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign out_data   = out_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule
